// File: rtl/pueo_scaler_pkg.sv
// Shared defaults and the readout FSM state type for the PUEO trigger scaler.
package pueo_scaler_pkg;

  localparam int unsigned NCHAN_DEFAULT    = 32;
  localparam int unsigned CNT_BITS_DEFAULT = 16;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } scal_state_e;

endpackage

// File: rtl/pueo_scaler_chan.sv
// One scaler channel: rising-edge detect, gate qualification and a saturating
// counter that clears (or restarts at 1) on the period pulse.
module pueo_scaler_chan #(
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                sysclk_i,
  input  logic                rst_n_i,
  input  logic                trig_i,
  input  logic                gate_i,
  input  logic                gate_en_i,
  input  logic                pps_i,
  output logic [CNT_BITS-1:0] count_o
);

  logic                trig_q;
  logic                hit;
  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    hit     = trig_i & ~trig_q & (~gate_en_i | gate_i);
    count_d = count_q;
    if (pps_i) begin
      count_d = CNT_BITS'(hit);
    end else if (hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trig_q  <= 1'b0;
      count_q <= '0;
    end else begin
      trig_q  <= trig_i;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pueo_scaler_counter.sv
// Per-channel trigger scalers with a per-period snapshot bank streamed out one
// channel per handshake; a period pulse arriving mid-readout is dropped and flagged.
module pueo_scaler_counter
  import pueo_scaler_pkg::*;
#(
  parameter int unsigned NCHAN    = NCHAN_DEFAULT,
  parameter int unsigned CNT_BITS = CNT_BITS_DEFAULT,
  localparam int unsigned ChanW   = $clog2(NCHAN)
) (
  input  logic                sysclk_i,
  input  logic                rst_n_i,
  input  logic [NCHAN-1:0]    trig_i,
  input  logic                gate_i,
  input  logic [NCHAN-1:0]    gate_en_i,
  input  logic                pps_i,
  output logic                scal_valid_o,
  input  logic                scal_ready_i,
  output logic [ChanW-1:0]    scal_chan_o,
  output logic [CNT_BITS-1:0] scal_data_o,
  output logic                scal_last_o,
  output logic                overrun_o,
  input  logic                overrun_clr_i
);

  localparam logic [ChanW-1:0] LastIdx = ChanW'(NCHAN - 1);

  logic [CNT_BITS-1:0] count  [NCHAN];
  logic [CNT_BITS-1:0] snap_q [NCHAN];
  scal_state_e         state_q;
  logic [ChanW-1:0]    idx_q;
  logic                overrun_q;
  logic                send;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    pueo_scaler_chan #(
      .CNT_BITS (CNT_BITS)
    ) u_chan (
      .sysclk_i  (sysclk_i),
      .rst_n_i   (rst_n_i),
      .trig_i    (trig_i[g]),
      .gate_i    (gate_i),
      .gate_en_i (gate_en_i[g]),
      .pps_i     (pps_i),
      .count_o   (count[g])
    );
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NCHAN; i++) snap_q[i] <= '0;
    end else begin
      if (overrun_clr_i) overrun_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Counters present pre-clear values this cycle; edges in the pps cycle go to next period.
          if (pps_i) begin
            for (int i = 0; i < NCHAN; i++) snap_q[i] <= count[i];
            state_q <= StSend;
            idx_q   <= '0;
          end
        end
        StSend: begin
          if (pps_i) overrun_q <= 1'b1;
          if (scal_ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    send         = (state_q == StSend);
    scal_valid_o = send;
    scal_chan_o  = send ? idx_q : '0;
    scal_data_o  = send ? snap_q[idx_q] : '0;
    scal_last_o  = send && (idx_q == LastIdx);
    overrun_o    = overrun_q;
  end

endmodule

// File: tb/tb_pueo_scaler_counter.sv
// Directed bench for pueo_scaler_counter: table of gated-count vectors plus
// hand sequences for pps collisions, back-pressure/overrun, reset and saturation.
module tb_pueo_scaler_counter;

  localparam int NCH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] trig, gate_en;
  logic        gate, pps, ready, clr;
  logic        valid, last, ovr;
  logic [4:0]  chan;
  logic [15:0] data;

  // Small instance so saturation is reachable in a short run.
  logic [3:0]  s_trig;
  logic        s_pps, s_valid, s_last, s_ovr;
  logic [1:0]  s_chan;
  logic [3:0]  s_data;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt [NCH];

  typedef struct {
    int   ch;
    logic en;
    int   n_g0;
    int   n_g1;
    int   expect_cnt;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  pueo_scaler_counter #(
    .NCHAN    (32),
    .CNT_BITS (16)
  ) u_dut (
    .sysclk_i      (clk),
    .rst_n_i       (rst_n),
    .trig_i        (trig),
    .gate_i        (gate),
    .gate_en_i     (gate_en),
    .pps_i         (pps),
    .scal_valid_o  (valid),
    .scal_ready_i  (ready),
    .scal_chan_o   (chan),
    .scal_data_o   (data),
    .scal_last_o   (last),
    .overrun_o     (ovr),
    .overrun_clr_i (clr)
  );

  pueo_scaler_counter #(
    .NCHAN    (4),
    .CNT_BITS (4)
  ) u_sat (
    .sysclk_i      (clk),
    .rst_n_i       (rst_n),
    .trig_i        (s_trig),
    .gate_i        (1'b0),
    .gate_en_i     (4'b0000),
    .pps_i         (s_pps),
    .scal_valid_o  (s_valid),
    .scal_ready_i  (1'b1),
    .scal_chan_o   (s_chan),
    .scal_data_o   (s_data),
    .scal_last_o   (s_last),
    .overrun_o     (s_ovr),
    .overrun_clr_i (1'b0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic edge_on(input int ch);
    trig[ch] = 1'b1;
    tick();
    trig[ch] = 1'b0;
    tick();
  endtask

  task automatic pps_pulse();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NCH; i++) exp_cnt[i] = 0;
  endtask

  // Expects word `first` presented now and the rest on consecutive cycles.
  task automatic read_words(input int first, input string tag);
    for (int k = first; k < NCH; k++) begin
      chk($sformatf("%s w%0d valid", tag, k), 32'(valid), 32'd1);
      chk($sformatf("%s w%0d chan", tag, k), 32'(chan), 32'(k));
      chk($sformatf("%s w%0d data", tag, k), 32'(data), 32'(exp_cnt[k]));
      chk($sformatf("%s w%0d last", tag, k), 32'(last), 32'(k == NCH - 1));
      tick();
    end
    chk($sformatf("%s idle valid", tag), 32'(valid), 32'd0);
    chk($sformatf("%s idle data", tag), 32'(data), 32'd0);
    chk($sformatf("%s idle chan", tag), 32'(chan), 32'd0);
  endtask

  initial begin
    vecs[0] = '{ch: 3,  en: 1'b0, n_g0: 5, n_g1: 0, expect_cnt: 5};
    vecs[1] = '{ch: 7,  en: 1'b1, n_g0: 4, n_g1: 3, expect_cnt: 3};
    vecs[2] = '{ch: 12, en: 1'b1, n_g0: 0, n_g1: 6, expect_cnt: 6};
    vecs[3] = '{ch: 31, en: 1'b0, n_g0: 2, n_g1: 2, expect_cnt: 4};
    vecs[4] = '{ch: 0,  en: 1'b1, n_g0: 5, n_g1: 0, expect_cnt: 0};
    vecs[5] = '{ch: 16, en: 1'b0, n_g0: 0, n_g1: 1, expect_cnt: 1};

    trig = '0; gate_en = '0; gate = 1'b0; pps = 1'b0; ready = 1'b1; clr = 1'b0;
    s_trig = '0; s_pps = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset overrun", 32'(ovr), 32'd0);
    chk("reset chan", 32'(chan), 32'd0);
    chk("reset data", 32'(data), 32'd0);
    chk("reset last", 32'(last), 32'd0);
    rst_n = 1'b1;
    tick();

    // Gated counting vectors.
    foreach (vecs[v]) begin
      gate_en = '0;
      gate_en[vecs[v].ch] = vecs[v].en;
      gate = 1'b0;
      repeat (vecs[v].n_g0) edge_on(vecs[v].ch);
      gate = 1'b1;
      repeat (vecs[v].n_g1) edge_on(vecs[v].ch);
      gate = 1'b0;
      clear_exp();
      exp_cnt[vecs[v].ch] = vecs[v].expect_cnt;
      pps_pulse();
      read_words(0, $sformatf("vec%0d", v));
    end
    gate_en = '0;

    // Edge coincident with pps belongs to the next period.
    trig[1] = 1'b1;
    pps = 1'b1;
    tick();
    trig[1] = 1'b0;
    pps = 1'b0;
    clear_exp();
    read_words(0, "same_pps1");
    pps_pulse();
    exp_cnt[1] = 1;
    read_words(0, "same_pps2");

    // Back-pressure at word 2, overrun while stalled, set beats clear.
    clear_exp();
    repeat (3) edge_on(2);
    edge_on(30);
    exp_cnt[2] = 3;
    exp_cnt[30] = 1;
    pps_pulse();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall w%0d chan", k), 32'(chan), 32'(k));
      tick();
    end
    ready = 1'b0;
    chk("stall chan", 32'(chan), 32'd2);
    repeat (4) edge_on(2);
    chk("stall hold chan", 32'(chan), 32'd2);
    chk("stall hold data", 32'(data), 32'd3);
    chk("stall hold valid", 32'(valid), 32'd1);
    chk("stall hold last", 32'(last), 32'd0);
    chk("stall no overrun yet", 32'(ovr), 32'd0);
    pps = 1'b1;
    clr = 1'b1;
    tick();
    pps = 1'b0;
    clr = 1'b0;
    chk("overrun set wins", 32'(ovr), 32'd1);
    chk("overrun hold chan", 32'(chan), 32'd2);
    chk("overrun hold data", 32'(data), 32'd3);
    tick();
    chk("overrun sticky", 32'(ovr), 32'd1);
    ready = 1'b1;
    read_words(2, "resume");
    chk("overrun after readout", 32'(ovr), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("overrun cleared", 32'(ovr), 32'd0);

    // Reset in the middle of a readout.
    clear_exp();
    edge_on(9);
    exp_cnt[9] = 1;
    pps_pulse();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("prerst w%0d chan", k), 32'(chan), 32'(k));
      chk($sformatf("prerst w%0d data", k), 32'(data), 32'(exp_cnt[k]));
      if (k == 5) pps = 1'b1;
      if (k == 6) begin
        pps = 1'b0;
        trig[20] = 1'b1;
      end
      if (k == 7) trig[20] = 1'b0;
      tick();
    end
    chk("prerst w10 chan", 32'(chan), 32'd10);
    chk("prerst overrun", 32'(ovr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst valid now", 32'(valid), 32'd0);
    chk("rst overrun now", 32'(ovr), 32'd0);
    chk("rst chan now", 32'(chan), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("postrst idle%0d valid", k), 32'(valid), 32'd0);
    end
    clear_exp();
    edge_on(4);
    exp_cnt[4] = 1;
    pps_pulse();
    read_words(0, "postrst");

    // Saturation on the 4-bit instance: 20 edges cap at 15.
    for (int i = 0; i < 20; i++) begin
      s_trig[0] = 1'b1;
      if (i < 7) s_trig[1] = 1'b1;
      tick();
      s_trig = '0;
      tick();
    end
    s_pps = 1'b1;
    tick();
    s_pps = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sat w%0d valid", k), 32'(s_valid), 32'd1);
      chk($sformatf("sat w%0d chan", k), 32'(s_chan), 32'(k));
      chk($sformatf("sat w%0d data", k), 32'(s_data),
          (k == 0) ? 32'd15 : (k == 1) ? 32'd7 : 32'd0);
      chk($sformatf("sat w%0d last", k), 32'(s_last), 32'(k == 3));
      tick();
    end
    chk("sat idle valid", 32'(s_valid), 32'd0);
    chk("sat overrun", 32'(s_ovr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pueo_scaler_counter.md
PUEO_SCALER_COUNTER -- requirements
Module: pueo_scaler_counter

Interface
REQ-001 Parameter NCHAN, default 32: number of trigger channels; must match the width of the gate-enable bus.
REQ-002 Parameter CNT_BITS, default 16: width of each channel counter.
REQ-003 Port sysclk_i, input, 1: sole clock; every flop in the block runs on it.
REQ-004 Port rst_n_i, input, 1: asynchronous, active-low reset; deassertion is synchronised to sysclk_i outside this block.
REQ-005 Port trig_i, input, NCHAN: per-channel trigger levels, already synchronous to sysclk_i.
REQ-006 Port gate_i, input, 1: gate level from the scaler register core.
REQ-007 Port gate_en_i, input, NCHAN: per-channel gate enable from the scaler register core.
REQ-008 Port pps_i, input, 1: single-cycle period-boundary pulse.
REQ-009 Port scal_valid_o, output, 1: readout word valid.
REQ-010 Port scal_ready_i, input, 1: downstream ready for the readout word.
REQ-011 Port scal_chan_o, output, clog2(NCHAN): channel index of the current word.
REQ-012 Port scal_data_o, output, CNT_BITS: snapshot count for that channel.
REQ-013 Port scal_last_o, output, 1: high on the word for channel NCHAN-1.
REQ-014 Port overrun_o, output, 1: sticky flag, set when a snapshot was dropped.
REQ-015 Port overrun_clr_i, input, 1: clears overrun_o.

Function
REQ-016 Each channel SHALL register trig_i and detect rising edges; edge at cycle N = trig_i high at N, low at N-1.
REQ-017 An edge SHALL be counted only when gate_en_i[i]==0 or gate_i==1, both sampled in the same cycle as the edge.
REQ-018 Counters SHALL saturate at 2^CNT_BITS-1 and never wrap.
REQ-019 On pps_i, each counter SHALL clear; a qualifying edge in the pps_i cycle loads the counter with 1 instead.
REQ-020 On pps_i with the FSM in IDLE, the pre-clear counter values (excluding any edge in the pps_i cycle) SHALL be copied into the snapshot bank, and the FSM SHALL enter SEND on the next cycle.
REQ-021 On pps_i with the FSM in SEND, the snapshot bank SHALL be left untouched, counters SHALL still clear, and overrun_o SHALL set.
REQ-022 FSM states: IDLE and SEND only; IDLE->SEND on pps_i; SEND->IDLE on a handshake while scal_last_o is high.
REQ-023 In SEND, scal_valid_o SHALL be 1 and scal_chan_o SHALL start at 0; the index SHALL advance by 1 on each handshake (scal_valid_o & scal_ready_i).
REQ-024 scal_chan_o, scal_data_o and scal_last_o SHALL hold stable while scal_valid_o is high and scal_ready_i is low.
REQ-025 Readout latency: the first word is valid 1 cycle after the pps_i cycle; with scal_ready_i held high, one word per cycle, NCHAN words in total.
REQ-026 overrun_clr_i SHALL clear overrun_o; if overrun_clr_i and an overrun set occur in the same cycle, set wins.
REQ-027 In IDLE, scal_valid_o SHALL be 0; scal_chan_o, scal_data_o and scal_last_o are don't-care but driven to 0.

Reset
REQ-028 Assertion of rst_n_i SHALL immediately clear all counters, the snapshot bank, the edge registers, overrun_o and scal_valid_o, and force the FSM to IDLE with index 0.
REQ-029 Reset during SEND SHALL abort the readout with no further words; the first pps_i after reset SHALL produce a full snapshot.

Structure
REQ-030 Package pueo_scaler_pkg SHALL hold NCHAN_DEFAULT, CNT_BITS_DEFAULT and the FSM state typedef.
REQ-031 The per-channel edge detect, gating and saturating counter SHALL be sub-module pueo_scaler_chan, generated NCHAN times.
REQ-032 The snapshot bank SHALL be a register array read by channel index, not a shift chain.

Verification
REQ-033 Setup: gate_en_i=0; 5 edges on ch3, then pps_i, scal_ready_i=1. Required: 32 words on consecutive cycles; ch3=5, all others=0; scal_last_o only on ch31.
REQ-034 Setup: gate_en_i[7]=1; 4 edges on ch7 with gate_i=0 and 3 edges with gate_i=1, then pps_i. Required: ch7=3.
REQ-035 Setup: 70000 edges on ch0 with CNT_BITS=16, then pps_i. Required: ch0=65535.
REQ-036 Setup: edge on ch1 in the same cycle as pps_i, then a second pps_i. Required: snapshot 1 shows ch1=0; snapshot 2 shows ch1=1.
REQ-037 Setup: scal_ready_i=0 after 2 words, then a second pps_i. Required: outputs stay stable, overrun_o=1, and the resumed words come from the first snapshot.
REQ-038 Setup: rst_n_i low during SEND at word 10. Required: scal_valid_o=0 immediately, overrun_o=0, and the next pps_i gives a full 32-word readout.
